vga_timing: RTL and testbench
=============================

VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 The block SHALL have the parameter H_ACTIVE, default 640: visible pixels per line.
REQ-002 The block SHALL have the parameter H_FP, default 16: horizontal front porch, in pixels.
REQ-003 The block SHALL have the parameter H_SYNC, default 96: horizontal sync width, in pixels.
REQ-004 The block SHALL have the parameter H_BP, default 48: horizontal back porch, in pixels.
REQ-005 The block SHALL have the parameter V_ACTIVE, default 480: visible lines per frame.
REQ-006 The block SHALL have the parameter V_FP, default 10: vertical front porch, in lines.
REQ-007 The block SHALL have the parameter V_SYNC, default 2: vertical sync width, in lines.
REQ-008 The block SHALL have the parameter V_BP, default 33: vertical back porch, in lines.
REQ-009 The block SHALL have the parameter SYNC_POL, default 0: asserted level of hsync/vsync (0 = active-low).
REQ-010 Port clk, input, 1 bit: the only clock; master 50 MHz.
REQ-011 Port clr, input, 1 bit: reset, synchronous and active-high.
REQ-012 Port pix_en, input, 1 bit: pixel-rate strobe (25 MHz tick); all counting SHALL happen only in cycles where it is 1.
REQ-013 Port hcount, output, 10 bits: current pixel column, 0..H_TOTAL-1.
REQ-014 Port vcount, output, 10 bits: current line, 0..V_TOTAL-1.
REQ-015 Port hsync, output, 1 bit: horizontal sync.
REQ-016 Port vsync, output, 1 bit: vertical sync.
REQ-017 Port video_on, output, 1 bit: high when hcount < H_ACTIVE and vcount < V_ACTIVE.
REQ-018 Port line_start, output, 1 bit: one-cycle pulse.
REQ-019 Port frame_start, output, 1 bit: one-cycle pulse.
REQ-020 Port frame_cnt, output, 8 bits: count of completed frames.

Function
REQ-021 H_TOTAL SHALL be H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL SHALL be V_ACTIVE+V_FP+V_SYNC+V_BP (525).
REQ-022 On a clk edge with pix_en=1, hcount SHALL increment by 1, and from H_TOTAL-1 SHALL wrap to 0.
REQ-023 vcount SHALL increment only on the hcount wrap, and from V_TOTAL-1 SHALL wrap to 0 together with hcount.
REQ-024 With pix_en=0, hcount, vcount, hsync, vsync and video_on SHALL hold their values.
REQ-025 The horizontal phase FSM SHALL have the states H_ACT, H_FPO, H_SYN and H_BPO, each entered at hcount = 0, H_ACTIVE, H_ACTIVE+H_FP and H_ACTIVE+H_FP+H_SYNC respectively.
REQ-026 The vertical phase FSM SHALL have the states V_ACT, V_FPO, V_SYN and V_BPO, advancing only on the hcount wrap, with the analogous boundaries.
REQ-027 hsync SHALL equal SYNC_POL exactly while the horizontal FSM is in H_SYN (hcount 656..751), and ~SYNC_POL otherwise.
REQ-028 vsync SHALL equal SYNC_POL exactly while the vertical FSM is in V_SYN (vcount 490..491), and ~SYNC_POL otherwise.
REQ-029 hsync, vsync and video_on SHALL be registers computed from next-counter values, so that they are glitch-free and aligned with hcount/vcount in the same cycle (zero skew).
REQ-030 line_start SHALL pulse for exactly one clk cycle in the cycle after pix_en advances hcount to 0.
REQ-031 frame_start SHALL pulse for one clk cycle in the cycle after hcount and vcount both become 0; it SHALL coincide with line_start.
REQ-032 If pix_en is held high continuously, line_start SHALL fire every H_TOTAL pix_en cycles and frame_start every H_TOTAL*V_TOTAL pix_en cycles.

Reset
REQ-033 With clr=1 at a clk edge, regardless of pix_en or current state, the block SHALL reset to:
- hcount=0, vcount=0, both FSMs in their ACT state, hsync=vsync=~SYNC_POL, video_on=1;
- line_start=0, frame_start=0, frame_cnt=0.
REQ-034 clr SHALL take priority over pix_en.
REQ-035 The first pix_en after clr is released SHALL advance hcount to 1, with no start pulses emitted for the reset position.

Configuration
REQ-036 With macro VGA_TIMING_FRAME_CNT_EN defined, frame_cnt SHALL increment by 1 (mod 256) in the same cycle each frame_start pulses, so 255 wraps to 0.
REQ-037 Without VGA_TIMING_FRAME_CNT_EN, frame_cnt SHALL be constant 0 and no counter register SHALL be synthesised.

Verification
REQ-038 Reset, then pix_en every 2nd clk for 800 pixels -> hsync low exactly for hcount 656..751, and line_start pulses once after hcount 799->0.
REQ-039 Run a full frame (420000 pix_en) -> vsync low only for vcount 490..491, video_on count 307200, and one frame_start pulse.
REQ-040 Hold pix_en=0 for 37 cycles at hcount=655 -> all outputs are frozen, then hsync asserts on the next pix_en.
REQ-041 Assert clr at hcount=700, vcount=491 with pix_en=1 -> next cycle hcount=0, vcount=0, hsync=vsync=1, and no pulses.
REQ-042 With VGA_TIMING_FRAME_CNT_EN defined, run 257 frames -> frame_cnt=1; without the macro -> frame_cnt stays 0.
REQ-043 Set SYNC_POL=1 and repeat REQ-038 -> hsync is high only for hcount 656..751.

Source files
------------

// File: rtl/vga_timing.sv
// VGA raster timing generator.
//
// Counts pixel columns and lines at the pixel-strobe rate and produces sync,
// blanking and start-of-line / start-of-frame markers. Horizontal and vertical
// phases are tracked by two small FSMs. All registered outputs are computed from
// the next counter values, so they change in the same cycle as hcount/vcount.
//
// Ports:
//   clk         master clock
//   clr         synchronous active-high reset (has priority over pix_en)
//   pix_en      pixel-rate strobe; state advances only when it is 1
//   hcount      current pixel column, 0..H_TOTAL-1
//   vcount      current line, 0..V_TOTAL-1
//   hsync       horizontal sync, level SYNC_POL while in the sync phase
//   vsync       vertical sync, level SYNC_POL while in the sync phase
//   video_on    high inside the visible area
//   line_start  one-cycle pulse after hcount advances to 0
//   frame_start one-cycle pulse after hcount and vcount both advance to 0
//   frame_cnt   completed-frame counter (mod 256)
//
// Build option: define VGA_TIMING_FRAME_CNT_EN to enable the frame counter;
// without it frame_cnt is tied to 0.

module vga_timing #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       pix_en,
  output logic [9:0] hcount,
  output logic [9:0] vcount,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_cnt
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST      = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_FPO_START = 10'(H_ACTIVE);
  localparam logic [9:0] H_SYN_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_BPO_START = 10'(H_ACTIVE + H_FP + H_SYNC);

  localparam logic [9:0] V_LAST      = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_FPO_START = 10'(V_ACTIVE);
  localparam logic [9:0] V_SYN_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_BPO_START = 10'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [1:0] {H_ACT, H_FPO, H_SYN, H_BPO} h_state_e;
  typedef enum logic [1:0] {V_ACT, V_FPO, V_SYN, V_BPO} v_state_e;

  h_state_e   h_state_q, h_state_d;
  v_state_e   v_state_q, v_state_d;
  logic [9:0] h_next, v_next;
  logic       h_wrap, v_wrap;

  // Next counter values and the phase they fall into.
  always_comb begin
    h_wrap = (hcount == H_LAST);
    v_wrap = (vcount == V_LAST);
    h_next = h_wrap ? 10'd0 : hcount + 10'd1;
    v_next = vcount;
    if (h_wrap) begin
      v_next = v_wrap ? 10'd0 : vcount + 10'd1;
    end

    h_state_d = h_state_q;
    unique case (h_state_q)
      H_ACT:   if (h_next == H_FPO_START) h_state_d = H_FPO;
      H_FPO:   if (h_next == H_SYN_START) h_state_d = H_SYN;
      H_SYN:   if (h_next == H_BPO_START) h_state_d = H_BPO;
      H_BPO:   if (h_next == 10'd0)       h_state_d = H_ACT;
      default: h_state_d = H_ACT;
    endcase

    // The vertical phase only moves on the last pixel of a line.
    v_state_d = v_state_q;
    if (h_wrap) begin
      unique case (v_state_q)
        V_ACT:   if (v_next == V_FPO_START) v_state_d = V_FPO;
        V_FPO:   if (v_next == V_SYN_START) v_state_d = V_SYN;
        V_SYN:   if (v_next == V_BPO_START) v_state_d = V_BPO;
        V_BPO:   if (v_next == 10'd0)       v_state_d = V_ACT;
        default: v_state_d = V_ACT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      hcount      <= 10'd0;
      vcount      <= 10'd0;
      h_state_q   <= H_ACT;
      v_state_q   <= V_ACT;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      video_on    <= 1'b1;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      // Pulses last one clk cycle even though pix_en is slower than clk.
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (pix_en) begin
        hcount      <= h_next;
        vcount      <= v_next;
        h_state_q   <= h_state_d;
        v_state_q   <= v_state_d;
        hsync       <= (h_state_d == H_SYN) ? SYNC_POL : ~SYNC_POL;
        vsync       <= (v_state_d == V_SYN) ? SYNC_POL : ~SYNC_POL;
        video_on    <= (h_state_d == H_ACT) && (v_state_d == V_ACT);
        line_start  <= h_wrap;
        frame_start <= h_wrap && v_wrap;
      end
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [7:0] frame_cnt_q;

  // Steps on the same edge that raises frame_start.
  always_ff @(posedge clk) begin
    if (clr) begin
      frame_cnt_q <= 8'd0;
    end else if (pix_en && h_wrap && v_wrap) begin
      frame_cnt_q <= frame_cnt_q + 8'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
`else
  assign frame_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_vga_timing.sv
// Self-checking bench for vga_timing.
//
// Three instances share clk/clr/pix_en: u_d0 (default 640x480 timing, active-low
// sync), u_d1 (default timing, active-high sync) and u_ds (a tiny 15x11 raster so
// whole frames and frame-counter wrap fit in a short run). The reference model is
// a single count of pixel strobes since the last clear; every expected output is
// derived from it with division and modulo.

module tb_vga_timing;

  localparam int unsigned D_HA = 640, D_HF = 16, D_HS = 96, D_HB = 48;
  localparam int unsigned D_VA = 480, D_VF = 10, D_VS = 2,  D_VB = 33;
  localparam int unsigned S_HA = 8,   S_HF = 2,  S_HS = 3,  S_HB = 2;
  localparam int unsigned S_VA = 6,   S_VF = 1,  S_VS = 2,  S_VB = 2;
  localparam int unsigned S_HT = S_HA + S_HF + S_HS + S_HB;
  localparam int unsigned S_VT = S_VA + S_VF + S_VS + S_VB;
  localparam int unsigned S_FR = S_HT * S_VT;

`ifdef VGA_TIMING_FRAME_CNT_EN
  localparam logic [7:0] FC_AFTER_257 = 8'd1;
`else
  localparam logic [7:0] FC_AFTER_257 = 8'd0;
`endif

  logic clk = 1'b0;
  logic clr = 1'b1;
  logic pix_en = 1'b0;

  logic [9:0] d0_hcount, d0_vcount, d1_hcount, d1_vcount, ds_hcount, ds_vcount;
  logic       d0_hsync, d0_vsync, d0_video_on, d0_line_start, d0_frame_start;
  logic       d1_hsync, d1_vsync, d1_video_on, d1_line_start, d1_frame_start;
  logic       ds_hsync, ds_vsync, ds_video_on, ds_line_start, ds_frame_start;
  logic [7:0] d0_frame_cnt, d1_frame_cnt, ds_frame_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  always #10 clk = ~clk;

  vga_timing u_d0 (
    .clk(clk), .clr(clr), .pix_en(pix_en), .hcount(d0_hcount), .vcount(d0_vcount),
    .hsync(d0_hsync), .vsync(d0_vsync), .video_on(d0_video_on),
    .line_start(d0_line_start), .frame_start(d0_frame_start), .frame_cnt(d0_frame_cnt)
  );

  vga_timing #(.SYNC_POL(1'b1)) u_d1 (
    .clk(clk), .clr(clr), .pix_en(pix_en), .hcount(d1_hcount), .vcount(d1_vcount),
    .hsync(d1_hsync), .vsync(d1_vsync), .video_on(d1_video_on),
    .line_start(d1_line_start), .frame_start(d1_frame_start), .frame_cnt(d1_frame_cnt)
  );

  vga_timing #(
    .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
    .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB), .SYNC_POL(1'b0)
  ) u_ds (
    .clk(clk), .clr(clr), .pix_en(pix_en), .hcount(ds_hcount), .vcount(ds_vcount),
    .hsync(ds_hsync), .vsync(ds_vsync), .video_on(ds_video_on),
    .line_start(ds_line_start), .frame_start(ds_frame_start), .frame_cnt(ds_frame_cnt)
  );

  // Output bundles: {hcount, vcount, hsync, vsync, video_on, line_start, frame_start, frame_cnt}
  logic [32:0] d0_vec, d1_vec, ds_vec;
  assign d0_vec = {d0_hcount, d0_vcount, d0_hsync, d0_vsync, d0_video_on, d0_line_start,
                   d0_frame_start, d0_frame_cnt};
  assign d1_vec = {d1_hcount, d1_vcount, d1_hsync, d1_vsync, d1_video_on, d1_line_start,
                   d1_frame_start, d1_frame_cnt};
  assign ds_vec = {ds_hcount, ds_vcount, ds_hsync, ds_vsync, ds_video_on, ds_line_start,
                   ds_frame_start, ds_frame_cnt};

  // Reference model: pixel strobes since clear, and whether the last edge advanced.
  int unsigned p   = 0;
  logic        adv = 1'b0;

  always @(posedge clk) begin
    if (clr) begin
      p   <= 0;
      adv <= 1'b0;
    end else if (pix_en) begin
      p   <= p + 1;
      adv <= 1'b1;
    end else begin
      adv <= 1'b0;
    end
  end

  function automatic logic m_sync(int unsigned c, int unsigned a, int unsigned f,
                                  int unsigned s, logic pol);
    return (c >= a + f && c < a + f + s) ? pol : ~pol;
  endfunction

  function automatic logic [32:0] m_out(int unsigned pc, logic a,
                                        int unsigned ha, int unsigned hf, int unsigned hs,
                                        int unsigned hb, int unsigned va, int unsigned vf,
                                        int unsigned vs, int unsigned vb, logic pol);
    int unsigned ht = ha + hf + hs + hb;
    int unsigned vt = va + vf + vs + vb;
    int unsigned h  = pc % ht;
    int unsigned v  = (pc / ht) % vt;
    logic        ls = a && (h == 0);
    logic        fs = ls && (v == 0);
    logic [7:0]  fc;
`ifdef VGA_TIMING_FRAME_CNT_EN
    fc = 8'((pc / (ht * vt)) % 256);
`else
    fc = 8'd0;
`endif
    return {10'(h), 10'(v), m_sync(h, ha, hf, hs, pol), m_sync(v, va, vf, vs, pol),
            (h < ha) && (v < va), ls, fs, fc};
  endfunction

  function automatic logic [32:0] exp_d0();
    return m_out(p, adv, D_HA, D_HF, D_HS, D_HB, D_VA, D_VF, D_VS, D_VB, 1'b0);
  endfunction

  function automatic logic [32:0] exp_d1();
    return m_out(p, adv, D_HA, D_HF, D_HS, D_HB, D_VA, D_VF, D_VS, D_VB, 1'b1);
  endfunction

  function automatic logic [32:0] exp_ds();
    return m_out(p, adv, S_HA, S_HF, S_HS, S_HB, S_VA, S_VF, S_VS, S_VB, 1'b0);
  endfunction

  // Drive inputs just after an edge so they are stable at the next one, then sample.
  task automatic tick(input logic en, input logic rst);
    pix_en = en;
    clr    = rst;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick(1'b0, 1'b1);
    repeat (50) tick(1'b1, 1'b0);
    repeat (3) tick(1'($urandom_range(0, 1)), 1'b1);
    n_checks++;
    if (d0_vec !== 33'h0_0000_1C00) $display("FAIL reset_d0 got %h want %h", d0_vec, 33'h0_0000_1C00);
    else n_pass++;
    n_checks++;
    if (d1_vec !== 33'h0_0000_0400) $display("FAIL reset_d1 got %h want %h", d1_vec, 33'h0_0000_0400);
    else n_pass++;
    n_checks++;
    if (ds_vec !== 33'h0_0000_1C00) $display("FAIL reset_ds got %h want %h", ds_vec, 33'h0_0000_1C00);
    else n_pass++;
    tick(1'b1, 1'b0);
    n_checks++;
    if (d0_hcount !== 10'd1) $display("FAIL first_pix_hcount got %0d want 1", d0_hcount);
    else n_pass++;
    n_checks++;
    if ({d0_line_start, d0_frame_start} !== 2'b00)
      $display("FAIL first_pix_pulses got %b want 00", {d0_line_start, d0_frame_start});
    else n_pass++;
  endtask

  // One full default line with pix_en every 2nd clk, both sync polarities.
  task automatic test_hline();
    logic [32:0] e0, e1;
    int ls_cnt = 0, hs0_cnt = 0, hs1_cnt = 0;
    tick(1'b1, 1'b1);
    for (int i = 0; i < 2 * (D_HA + D_HF + D_HS + D_HB); i++) begin
      tick(1'(i % 2 == 0), 1'b0);
      e0 = exp_d0();
      e1 = exp_d1();
      if (adv && d0_hsync == 1'b0) hs0_cnt++;
      if (adv && d1_hsync == 1'b1) hs1_cnt++;
      if (d0_line_start) ls_cnt++;
      n_checks++;
      if (d0_hsync !== e0[12]) $display("FAIL hline_hsync_lo h=%0d got %b want %b",
                                        d0_hcount, d0_hsync, e0[12]);
      else n_pass++;
      n_checks++;
      if (d1_hsync !== e1[12]) $display("FAIL hline_hsync_hi h=%0d got %b want %b",
                                        d1_hcount, d1_hsync, e1[12]);
      else n_pass++;
      n_checks++;
      if (d0_line_start !== e0[9]) $display("FAIL hline_line_start h=%0d got %b want %b",
                                            d0_hcount, d0_line_start, e0[9]);
      else n_pass++;
    end
    n_checks++;
    if (ls_cnt !== 1) $display("FAIL hline_ls_count got %0d want 1", ls_cnt);
    else n_pass++;
    n_checks++;
    if (hs0_cnt !== int'(D_HS)) $display("FAIL hline_sync_lo_width got %0d want %0d", hs0_cnt, D_HS);
    else n_pass++;
    n_checks++;
    if (hs1_cnt !== int'(D_HS)) $display("FAIL hline_sync_hi_width got %0d want %0d", hs1_cnt, D_HS);
    else n_pass++;
    n_checks++;
    if ({d0_hcount, d0_vcount} !== {10'd0, 10'd1})
      $display("FAIL hline_end_pos got %0d,%0d want 0,1", d0_hcount, d0_vcount);
    else n_pass++;
  endtask

  // Freeze just before horizontal sync, then one strobe enters sync.
  task automatic test_hold();
    logic [32:0] e;
    tick(1'b1, 1'b1);
    repeat (655) tick(1'b1, 1'b0);
    for (int i = 0; i < 37; i++) begin
      tick(1'b0, 1'b0);
      e = exp_d0();
      n_checks++;
      if (d0_vec !== e) $display("FAIL hold_frozen cyc=%0d got %h want %h", i, d0_vec, e);
      else n_pass++;
    end
    n_checks++;
    if (d0_hcount !== 10'd655) $display("FAIL hold_hcount got %0d want 655", d0_hcount);
    else n_pass++;
    tick(1'b1, 1'b0);
    n_checks++;
    if ({d0_hcount, d0_hsync, d1_hsync} !== {10'd656, 1'b0, 1'b1})
      $display("FAIL hold_release got h=%0d hs=%b/%b want h=656 hs=0/1",
               d0_hcount, d0_hsync, d1_hsync);
    else n_pass++;
  endtask

  // One small frame with random strobes; counts visible and vsync positions.
  task automatic test_frame();
    logic [32:0] e;
    int von = 0, vsn = 0, fsn = 0;
    tick(1'b1, 1'b1);
    for (int i = 0; i < 4000 && p < S_FR; i++) begin
      tick(1'($urandom_range(0, 3) != 0), 1'b0);
      e = exp_ds();
      if (adv && ds_video_on) von++;
      if (adv && !ds_vsync) vsn++;
      if (ds_frame_start) fsn++;
      n_checks++;
      if (ds_vec[32:8] !== e[32:8]) $display("FAIL frame_outputs p=%0d got %h want %h",
                                             p, ds_vec[32:8], e[32:8]);
      else n_pass++;
    end
    if (p != S_FR) begin
      n_checks++;
      $display("FAIL frame_timeout got %0d strobes want %0d", p, S_FR);
    end
    n_checks++;
    if (von !== int'(S_HA * S_VA)) $display("FAIL frame_video_on_count got %0d want %0d",
                                            von, S_HA * S_VA);
    else n_pass++;
    n_checks++;
    if (vsn !== int'(S_VS * S_HT)) $display("FAIL frame_vsync_count got %0d want %0d",
                                            vsn, S_VS * S_HT);
    else n_pass++;
    n_checks++;
    if (fsn !== 1) $display("FAIL frame_start_count got %0d want 1", fsn);
    else n_pass++;
  endtask

  // Clear in the middle of both sync phases while pix_en is high.
  task automatic test_clr_mid();
    tick(1'b1, 1'b1);
    repeat ((S_VA + S_VF + 1) * S_HT + S_HA + S_HF + 1) tick(1'b1, 1'b0);
    n_checks++;
    if ({ds_hsync, ds_vsync} !== 2'b00)
      $display("FAIL clr_mid_pre_sync got %b want 00", {ds_hsync, ds_vsync});
    else n_pass++;
    tick(1'b1, 1'b1);
    n_checks++;
    if (ds_vec[32:8] !== {10'd0, 10'd0, 5'b11100})
      $display("FAIL clr_mid_state got %h want %h", ds_vec[32:8], {10'd0, 10'd0, 5'b11100});
    else n_pass++;
    n_checks++;
    if (ds_frame_cnt !== 8'd0) $display("FAIL clr_mid_frame_cnt got %0d want 0", ds_frame_cnt);
    else n_pass++;
  endtask

  // 257 back-to-back small frames: pulse periods and frame counter wrap.
  task automatic test_frame_cnt();
    logic [32:0] e;
    int lsn = 0, fsn = 0, last_ls = -1;
    tick(1'b1, 1'b1);
    for (int i = 0; i < int'(257 * S_FR); i++) begin
      tick(1'b1, 1'b0);
      if (ds_line_start) begin
        lsn++;
        if (last_ls >= 0) begin
          n_checks++;
          if (int'(p) - last_ls !== int'(S_HT))
            $display("FAIL fc_line_period got %0d want %0d", int'(p) - last_ls, S_HT);
          else n_pass++;
        end
        last_ls = int'(p);
      end
      if (ds_frame_start) begin
        fsn++;
        e = exp_ds();
        n_checks++;
        if (ds_frame_cnt !== e[7:0]) $display("FAIL fc_value frame=%0d got %0d want %0d",
                                              fsn, ds_frame_cnt, e[7:0]);
        else n_pass++;
      end
    end
    n_checks++;
    if (ds_frame_cnt !== FC_AFTER_257)
      $display("FAIL fc_after_257 got %0d want %0d", ds_frame_cnt, FC_AFTER_257);
    else n_pass++;
    n_checks++;
    if (lsn !== int'(257 * S_VT)) $display("FAIL fc_ls_count got %0d want %0d", lsn, 257 * S_VT);
    else n_pass++;
    n_checks++;
    if (fsn !== 257) $display("FAIL fc_fs_count got %0d want 257", fsn);
    else n_pass++;
    e = exp_d0();
    n_checks++;
    if (d0_vec[32:13] !== e[32:13]) $display("FAIL fc_d0_pos got %h want %h",
                                              d0_vec[32:13], e[32:13]);
    else n_pass++;
  endtask

  // Random strobes with occasional clears; full output compare on all instances.
  task automatic test_random();
    logic [32:0] e;
    for (int i = 0; i < 3000; i++) begin
      tick(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 199) == 0));
      e = exp_d0();
      n_checks++;
      if (d0_vec !== e) $display("FAIL rnd_d0 p=%0d got %h want %h", p, d0_vec, e);
      else n_pass++;
      e = exp_d1();
      n_checks++;
      if (d1_vec !== e) $display("FAIL rnd_d1 p=%0d got %h want %h", p, d1_vec, e);
      else n_pass++;
      e = exp_ds();
      n_checks++;
      if (ds_vec !== e) $display("FAIL rnd_ds p=%0d got %h want %h", p, ds_vec, e);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_hline();
    test_hold();
    test_frame();
    test_clr_mid();
    test_frame_cnt();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
